cfg_chain_loader: RTL and testbench
===================================

Name: cfg_chain_loader

Overview:
Bitstream transmitter for the fabric configuration shift chain. Accepts configuration words over a valid/ready interface and serializes them one bit per cycle into the head of the tile chain (shift_in_from_north / set_in_from_north of the first tile). Once exactly CHAIN_LEN bits have been shifted, it pulses the chain-wide set so every tile latches its configuration. Sits between the SoC-side config port and the top row of the fabric.

Parameters:
WORD_W, 32, width of an incoming configuration word
CHAIN_LEN, 1024, total bits in the tile shift chain (>=1)
SET_CYCLES, 1, cycles set_out is held high (>=1)
CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a load; sampled only in IDLE
cfg_data  in  WORD_W  configuration word
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  loader accepts word this cycle
shift_out  out  1  serial bit to chain head shift input
cen_out  out  1  chain shift enable; high exactly on cycles carrying a valid bit
set_out  out  1  to chain head set input
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after set completes
chain_tail_in  in  1  serial output of last tile (readback)
rb_data  out  WORD_W  readback word
rb_valid  out  1  rb_data valid pulse

Behaviour:
- All outputs registered; no combinational input-to-output paths.
- Reset: state IDLE, cfg_ready=0, shift_out=0, cen_out=0, set_out=0, busy=0, done=0, rb_data=0, rb_valid=0, bit counter=0, shift register=0.
- FSM states: IDLE, LOAD, SHIFT, SET, DONE.
- IDLE: start=1 -> LOAD; bit counter cleared. cfg_valid is ignored (cfg_ready=0).
- LOAD: cfg_ready=1. If cfg_valid=1, capture cfg_data into the shift register, go to SHIFT; otherwise stall in LOAD indefinitely.
- SHIFT: each cycle drive shift_out=sr[0] and cen_out=1, shift sr right by 1, increment the bit counter.
  - Bits are sent LSB first; bit 0 of word 0 is the first bit out and ends deepest in the chain.
  - The word ends after WORD_W bits or when the counter reaches CHAIN_LEN, whichever is first. Next state is SET if counter==CHAIN_LEN, else LOAD.
  - The final word uses only its low ((CHAIN_LEN-1) mod WORD_W)+1 bits; upper bits are discarded.
- Word count per load = ceil(CHAIN_LEN/WORD_W).
- Throughput: one word per WORD_W+1 cycles when cfg_valid is held high (one LOAD cycle plus WORD_W SHIFT cycles).
- SET: set_out=1 for SET_CYCLES consecutive cycles, cen_out=0, shift_out=0, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- start asserted while busy is ignored. cfg_valid outside LOAD is ignored.
- Reset mid-load returns to IDLE with set_out never asserted, so a partial bitstream is never committed. Chain contents are left undefined.
- Counter never exceeds CHAIN_LEN. With CHAIN_LEN < WORD_W the load is a single word.

Optional Feature:
CFG_CHAIN_READBACK_EN
- Defined:
  - On every cycle with cen_out=1, sample chain_tail_in and shift it into rb_data at bit index k (k = bits collected in the current readback word, LSB first).
  - rb_valid pulses one cycle when WORD_W bits have been collected, or when the final partial word completes; unused upper bits of a partial word are 0.
  - The old chain contents are thus streamed out in the same word format as they were loaded.
- Undefined: rb_data=0 and rb_valid=0 constantly; chain_tail_in is unused. The port list is unchanged.

Test Plan:
1. CHAIN_LEN=72, WORD_W=32, words 0x89ABCDEF, 0x01234567, 0x000000A5, cfg_valid held high -> 72 cen_out cycles; shift_out sequence matches the words LSB first (starts 1,1,1,1,0,1,1,1); last 8 bits are 1,0,1,0,0,1,0,1; set_out high 1 cycle; done one cycle later; busy drops the cycle after done.
2. Same load with a 5-cycle cfg_valid gap before word 1 -> cfg_ready held, cen_out=0 during the gap, identical serial sequence, total busy time grows by exactly 5 cycles.
3. Reset asserted after 40 bits -> next cycle all outputs 0, state IDLE; set_out never pulses; a fresh start then performs a full 72-bit load.
4. start pulses while busy, and cfg_valid pulses in IDLE -> no effect; word count and bit count are unchanged.
5. CHAIN_LEN=8, SET_CYCLES=3, word 0xFFFFFF3C -> exactly 8 bits (0,0,1,1,1,1,0,0) out, set_out high 3 cycles, done pulse.
6. CFG_CHAIN_READBACK_EN defined, chain_tail_in driven by a 72-bit shift-register model preloaded with 0xDEADBEEF, 0xCAFEF00D, 0x5A -> rb_valid pulses 3 times with rb_data = 0xDEADBEEF, 0xCAFEF00D, 0x0000005A.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// Serializes configuration words LSB first into the tile shift chain, then pulses set.
// Define CFG_CHAIN_READBACK_EN to stream the old chain contents back out on rb_data.
module cfg_chain_loader #(
  parameter int WORD_W     = 32,
  parameter int CHAIN_LEN  = 1024,
  parameter int SET_CYCLES = 1,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              shift_out,
  output logic              cen_out,
  output logic              set_out,
  output logic              busy,
  output logic              done,
  input  logic              chain_tail_in,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int BIT_W = $clog2(WORD_W + 1);
  localparam int SC_W  = $clog2(SET_CYCLES + 1);
  localparam logic [CNT_W-1:0] LEN   = CNT_W'(CHAIN_LEN);
  localparam logic [BIT_W-1:0] WLAST = BIT_W'(WORD_W - 1);
  localparam logic [SC_W-1:0]  SLAST = SC_W'(SET_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SHIFT, SET, DONE
  } state_t;

  state_t            st, st_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [BIT_W-1:0]  wb, wb_nx;
  logic [SC_W-1:0]   sc, sc_nx;
  logic [WORD_W-1:0] sr, sr_nx;
  logic rdy_nx, so_nx, cen_nx, set_nx;
  logic busy_nx, done_nx;

  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    wb_nx  = wb;
    sc_nx  = sc;
    sr_nx  = sr;
    unique case (st)
      IDLE: begin
        if (start) begin
          st_nx  = LOAD;
          cnt_nx = '0;
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          sr_nx = cfg_data;
          wb_nx = '0;
          st_nx = SHIFT;
        end
      end
      SHIFT: begin
        sr_nx  = sr >> 1;
        cnt_nx = cnt + 1'b1;
        wb_nx  = wb + 1'b1;
        if (cnt_nx == LEN) begin
          st_nx = SET;
          sc_nx = '0;
        end else if (wb == WLAST) begin
          st_nx = LOAD;
        end
      end
      SET: begin
        sc_nx = sc + 1'b1;
        if (sc == SLAST) st_nx = DONE;
      end
      DONE: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // ready tracks the next state so the handshake lands in LOAD;
  // the serial/set/done outputs trail the state by one register stage
  always_comb begin
    rdy_nx  = (st_nx == LOAD);
    cen_nx  = (st == SHIFT);
    so_nx   = (st == SHIFT) && sr[0];
    set_nx  = (st == SET);
    done_nx = (st == DONE);
    busy_nx = (st != IDLE) || (st_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      wb        <= '0;
      sc        <= '0;
      sr        <= '0;
      cfg_ready <= 1'b0;
      shift_out <= 1'b0;
      cen_out   <= 1'b0;
      set_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      st        <= st_nx;
      cnt       <= cnt_nx;
      wb        <= wb_nx;
      sc        <= sc_nx;
      sr        <= sr_nx;
      cfg_ready <= rdy_nx;
      shift_out <= so_nx;
      cen_out   <= cen_nx;
      set_out   <= set_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

`ifdef CFG_CHAIN_READBACK_EN
  logic [WORD_W-1:0] rb_acc, acc_nx;
  logic [BIT_W-1:0]  rb_k;
  logic [CNT_W-1:0]  rb_n;
  logic              rb_last;

  always_comb begin
    acc_nx  = (rb_k == '0) ? '0 : rb_acc;
    acc_nx  = acc_nx | (WORD_W'(chain_tail_in) << rb_k);
    rb_last = (rb_k == WLAST) || (rb_n == LEN - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_acc   <= '0;
      rb_k     <= '0;
      rb_n     <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (st == IDLE && start) begin
        rb_k <= '0;
        rb_n <= '0;
      end else if (cen_out) begin
        rb_acc <= acc_nx;
        rb_n   <= rb_n + 1'b1;
        if (rb_last) begin
          rb_k     <= '0;
          rb_data  <= acc_nx;
          rb_valid <= 1'b1;
        end else begin
          rb_k <= rb_k + 1'b1;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = chain_tail_in;
  assign rb_data     = '0;
  assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: two instances (72-bit and 8-bit chains),
// each driven into a behavioural chain model that feeds chain_tail_in.
module tb_cfg_chain_loader;

  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic cfg_valid [2];
  logic [31:0] cfg_data [2];
  logic rdy [2], so [2], cen [2], set_o [2];
  logic busy [2], done [2], rbv [2], tail [2];
  logic [31:0] rbd [2];

  logic [71:0] ch0 = '0;
  logic [7:0]  ch1 = '0;

  always #5 clk = ~clk;

  cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(72), .SET_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .cfg_data(cfg_data[0]), .cfg_valid(cfg_valid[0]),
    .cfg_ready(rdy[0]), .shift_out(so[0]), .cen_out(cen[0]),
    .set_out(set_o[0]), .busy(busy[0]), .done(done[0]),
    .chain_tail_in(tail[0]), .rb_data(rbd[0]), .rb_valid(rbv[0])
  );

  cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(8), .SET_CYCLES(3)) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .cfg_data(cfg_data[1]), .cfg_valid(cfg_valid[1]),
    .cfg_ready(rdy[1]), .shift_out(so[1]), .cen_out(cen[1]),
    .set_out(set_o[1]), .busy(busy[1]), .done(done[1]),
    .chain_tail_in(tail[1]), .rb_data(rbd[1]), .rb_valid(rbv[1])
  );

  // chain model: bit enters at index 0, oldest bit sits at the tail
  always @(posedge clk) begin
    if (cen[0]) ch0 <= {ch0[70:0], so[0]};
    if (cen[1]) ch1 <= {ch1[6:0], so[1]};
  end
  assign tail[0] = ch0[71];
  assign tail[1] = ch1[7];

  int total = 0, bad = 0;
  int cur = 0, L = 72, S = 1;
  int bits_seen, set_run, done_seen, busy_cyc, gap_tot;
  bit prev_set;
  bit expq [$];
  logic [31:0] rbq [$];
  logic [31:0] wl [3];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cen[cur]) begin
          if (expq.size() == 0) chk("extra_bit", 1, 0);
          else chk("bit", int'(so[cur]), int'(expq.pop_front()));
          bits_seen++;
        end
        if (set_o[cur]) begin
          chk("set_early", bits_seen, L);
          set_run++;
        end
        if (done[cur]) begin
          chk("set_len", set_run, S);
          chk("done_after_set", int'(prev_set), 1);
          set_run = 0;
          done_seen++;
        end
        if (busy[cur]) busy_cyc++;
        if (rbv[cur]) begin
          if (rbq.size() == 0) chk("extra_rb", 1, 0);
          else chk("rb_data", int'(rbd[cur]), int'(rbq.pop_front()));
        end
        prev_set = set_o[cur];
      end
    end
  endtask

  function automatic logic old_bit(input int d, input int idx);
    return d ? ch1[L-1-idx] : ch0[L-1-idx];
  endfunction

  task automatic run_load(input int d, input int nw, input int gap_at,
                          input int gap_n, input bit rnd, input int abort_at);
    int n, g;
    cur = d;
    L = d ? 8 : 72;
    S = d ? 3 : 1;
    expq.delete();
    rbq.delete();
    for (int i = 0; i < L; i++) expq.push_back(wl[i/32][i%32]);
`ifdef CFG_CHAIN_READBACK_EN
    for (int i = 0; i < nw; i++) begin
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < 32; b++)
        if (i*32 + b < L) w[b] = old_bit(d, i*32 + b);
      rbq.push_back(w);
    end
`endif
    bits_seen = 0; set_run = 0; done_seen = 0;
    busy_cyc = 0; gap_tot = 0; prev_set = 0;
    if (rnd && $urandom_range(1) == 1) begin
      cfg_valid[d] = 1'b1;
      cfg_data[d] = $urandom;
      @(negedge clk);
      chk("idle_ready", int'(rdy[d]), 0);
      cfg_valid[d] = 1'b0;
    end
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    for (int k = 0; k < nw; k++) begin
      n = 0;
      while (!rdy[d] && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!rdy[d]) begin
        chk("ready_timeout", 0, 1);
        break;
      end
      g = (k == gap_at) ? gap_n : (rnd ? int'($urandom_range(3)) : 0);
      gap_tot += g;
      repeat (g) begin
        @(negedge clk);
        chk("gap_cen", int'(cen[d]), 0);
        chk("gap_ready", int'(rdy[d]), 1);
      end
      cfg_valid[d] = 1'b1;
      cfg_data[d] = wl[k];
      @(negedge clk);
      cfg_valid[d] = 1'b0;
      cfg_data[d] = $urandom;
      if (rnd && $urandom_range(1) == 1) begin
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
      end
      if (abort_at > 0 && k == 1) break;
    end
    if (abort_at > 0) begin
      n = 0;
      while (bits_seen < abort_at && n < 200) begin
        @(posedge clk);
        n++;
      end
      chk("abort_reach", bits_seen, abort_at);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_outs", int'({rdy[d], so[d], cen[d], set_o[d],
                            busy[d], done[d], rbv[d]}), 0);
      chk("rst_rbd", int'(rbd[d]), 0);
      rst = 1'b0;
      expq.delete();
      rbq.delete();
      bits_seen = 0;
      set_run = 0;
      repeat (6) begin
        @(negedge clk);
        chk("post_rst_idle", int'({set_o[d], busy[d], cen[d]}), 0);
      end
      return;
    end
    n = 0;
    while (done_seen == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_once", done_seen, 1);
    chk("busy_drop", int'(busy[d]), 0);
    chk("busy_len", busy_cyc, nw + L + S + 2 + gap_tot);
    chk("bits_total", bits_seen, L);
    chk("exp_left", expq.size(), 0);
`ifdef CFG_CHAIN_READBACK_EN
    chk("rb_left", rbq.size(), 0);
`else
    chk("rb_zero", int'(rbd[d]), 0);
`endif
  endtask

  task automatic rand_words();
    for (int i = 0; i < 3; i++) wl[i] = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      cfg_valid[d] = 1'b0;
      cfg_data[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outs", int'({rdy[d], so[d], cen[d], set_o[d],
                              busy[d], done[d], rbv[d]}), 0);
      chk("reset_rbd", int'(rbd[d]), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    fork
      monitor();
    join_none

    wl = '{32'h89ABCDEF, 32'h01234567, 32'h000000A5};
    run_load(0, 3, -1, 0, 0, 0);
    run_load(0, 3, 1, 5, 0, 0);
    wl = '{32'hDEADBEEF, 32'hCAFEF00D, 32'h0000005A};
    run_load(0, 3, -1, 0, 0, 0);
    rand_words();
    run_load(0, 3, -1, 0, 1, 0);
    rand_words();
    run_load(0, 3, -1, 0, 0, 40);
    rand_words();
    run_load(0, 3, -1, 0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      rand_words();
      run_load(0, 3, -1, 0, 1, 0);
    end

    wl[0] = 32'hFFFFFF3C;
    run_load(1, 1, -1, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      rand_words();
      run_load(1, 1, -1, 0, 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
